// File: rtl/stream_muxn_if.sv
// stream_muxn_if: channel bundle for the N-input stream multiplexer.
//
// Signals:
//   in_data   N*WIDTH  producer data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  N        per-channel valid from producers
//   in_ready  N        per-channel ready back to producers
//   out_data  WIDTH    registered merged data to the consumer
//   out_chan  SELW     channel index that supplied out_data
//   out_valid 1        output beat valid
//   out_ready 1        consumer ready
//
// Modports:
//   master  producer/consumer side (drives inputs, observes outputs)
//   slave   multiplexer side
interface stream_muxn_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
);
    localparam int unsigned SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_chan,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_chan,
        output out_valid
    );
endinterface

// File: rtl/stream_muxn.sv
// stream_muxn: N-input registered stream multiplexer with valid/ready
// handshake on every channel. Fixed-select (mode=0) or round-robin
// arbitration (mode=1). One-cycle latency, one beat per cycle throughput.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   mode     0 = fixed select via sel, 1 = round-robin
//   sel      channel index used when mode=0 (values >= N grant nothing)
//   bus      stream_muxn_if.slave: per-channel inputs, merged output
module stream_muxn #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    stream_muxn_if.slave    bus
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    logic             load;
    logic [N-1:0]     grant;
    logic [N-1:0]     in_ready;
    logic             accept;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;

    // Output register can take a beat when empty or being popped this cycle.
    always_comb load = ~out_valid_q | bus.out_ready;

    always_comb begin : grant_logic
        logic [SELW:0]   cand;
        logic [SELW-1:0] idx;
        logic            found;
        grant = '0;
        cand  = '0;
        idx   = '0;
        found = 1'b0;
        if (load) begin
            if (!mode) begin
                // One extra bit so sel values >= N (non power-of-two N) are excluded.
                if ({1'b0, sel} < (SELW+1)'(N)) begin
                    grant[sel] = bus.in_valid[sel];
                end
            end else begin
                // Search rr_ptr+1 .. rr_ptr+N modulo N; the first valid wins.
                for (int unsigned k = 1; k <= N; k++) begin
                    cand = {1'b0, rr_ptr_q} + (SELW+1)'(k);
                    if (cand >= (SELW+1)'(N)) begin
                        cand = cand - (SELW+1)'(N);
                    end
                    idx = cand[SELW-1:0];
                    if (!found && bus.in_valid[idx]) begin
                        grant[idx] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    end

    always_comb in_ready = grant & {N{reset_n}};
    always_comb accept   = |in_ready;

    // Grant is one-hot, so OR-reduction of masked lanes selects the winner.
    always_comb begin : grant_encode
        grant_idx  = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx  = grant_idx | SELW'(i);
                grant_data = grant_data | bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin : next_state
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            rr_ptr_d    = grant_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= SELW'(N-1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_muxn.sv
module tb_stream_muxn;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       mode4;
    logic [1:0] sel4;
    logic       mode5;
    logic [2:0] sel5;

    stream_muxn_if #(.WIDTH(W), .N(4)) bus4 ();
    stream_muxn_if #(.WIDTH(W), .N(5)) bus5 ();

    stream_muxn #(.WIDTH(W), .N(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode4),
        .sel     (sel4),
        .bus     (bus4.slave)
    );

    stream_muxn #(.WIDTH(W), .N(5)) u_dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .mode    (mode5),
        .sel     (sel5),
        .bus     (bus5.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model of the N=4 instance: output register contents and
    // the last channel served.
    bit m_valid;
    int m_data;
    int m_chan;
    int m_rr;
    int m_last_g;

    task automatic step4();
        int       g;
        bit       load;
        logic [3:0] exp_rdy;
        #1;
        g    = -1;
        load = !m_valid || bus4.out_ready;
        if (reset_n && load) begin
            if (!mode4) begin
                if (bus4.in_valid[sel4]) g = int'(sel4);
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_rr + k) % 4;
                    if (g < 0 && bus4.in_valid[c]) g = c;
                end
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check_eq("in_ready", 32'(bus4.in_ready), 32'(exp_rdy));
        m_last_g = g;
        if (!reset_n) begin
            m_valid = 0; m_data = 0; m_chan = 0; m_rr = 3;
        end else if (g >= 0) begin
            m_valid = 1;
            m_data  = int'(bus4.in_data[g*W +: W]);
            m_chan  = g;
            m_rr    = g;
        end else if (m_valid && bus4.out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(bus4.out_valid), 32'(m_valid));
        check_eq("out_data",  32'(bus4.out_data),  32'(m_data));
        check_eq("out_chan",  32'(bus4.out_chan),  32'(m_chan));
    endtask

    task automatic set_data4(input int ch, input logic [7:0] d);
        bus4.in_data[ch*W +: W] = d;
    endtask

    initial begin
        reset_n = 1'b0;
        mode4 = 1'b1; sel4 = '0; mode5 = 1'b0; sel5 = '0;
        bus4.in_valid = 4'hF; bus4.in_data = '0; bus4.out_ready = 1'b1;
        bus5.in_valid = 5'h1F; bus5.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) bus5.in_data[i*W +: W] = 8'(8'h20 + i);
        m_valid = 0; m_data = 0; m_chan = 0; m_rr = 3; m_last_g = -1;

        // ---------------- N=5 instance: out-of-range sel and wrap ----------
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("n5_rst_ready", 32'(bus5.in_ready), 32'h0);
            check_eq("n5_rst_valid", 32'(bus5.out_valid), 32'h0);
            check_eq("n5_rst_data", 32'(bus5.out_data), 32'h0);
            check_eq("n5_rst_chan", 32'(bus5.out_chan), 32'h0);
        end
        reset_n = 1'b1;
        bus4.in_valid = '0;
        mode4 = 1'b0;
        sel5 = 3'd4;
        #1;
        check_eq("n5_sel4_ready", 32'(bus5.in_ready), 32'h10);
        @(posedge clk); #1;
        check_eq("n5_sel4_chan", 32'(bus5.out_chan), 32'd4);
        check_eq("n5_sel4_data", 32'(bus5.out_data), 32'h24);
        check_eq("n5_sel4_valid", 32'(bus5.out_valid), 32'h1);
        sel5 = 3'd5;
        #1;
        check_eq("n5_sel5_ready", 32'(bus5.in_ready), 32'h0);
        @(posedge clk); #1;
        check_eq("n5_sel5_valid", 32'(bus5.out_valid), 32'h0);
        sel5 = 3'd7;
        #1;
        check_eq("n5_sel7_ready", 32'(bus5.in_ready), 32'h0);
        @(posedge clk); #1;
        check_eq("n5_sel7_valid", 32'(bus5.out_valid), 32'h0);
        mode5 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            check_eq("n5_rr_ready", 32'(bus5.in_ready), 32'(1 << (j % 5)));
            @(posedge clk); #1;
            check_eq("n5_rr_chan", 32'(bus5.out_chan), 32'(j % 5));
            check_eq("n5_rr_data", 32'(bus5.out_data), 32'(8'h20 + j % 5));
        end
        bus5.in_valid = '0;

        // ---------------- N=4 instance: directed --------------------------
        reset_n = 1'b0; mode4 = 1'b1; bus4.in_valid = 4'hF; bus4.out_ready = 1'b1;
        step4(); step4();
        check_eq("rst_valid", 32'(bus4.out_valid), 32'h0);
        check_eq("rst_data",  32'(bus4.out_data),  32'h0);
        check_eq("rst_chan",  32'(bus4.out_chan),  32'h0);

        reset_n = 1'b1; mode4 = 1'b0; sel4 = 2'd2;
        bus4.in_data = '0; set_data4(2, 8'hA5); bus4.in_valid = 4'b0100;
        step4();
        check_eq("fix_data",  32'(bus4.out_data),  32'hA5);
        check_eq("fix_chan",  32'(bus4.out_chan),  32'd2);
        check_eq("fix_valid", 32'(bus4.out_valid), 32'h1);
        bus4.in_valid = '0;
        step4();
        check_eq("fix_drain", 32'(bus4.out_valid), 32'h0);

        reset_n = 1'b0; step4(); reset_n = 1'b1;
        mode4 = 1'b1; bus4.in_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_data4(i, 8'(8'h10 + i));
        for (int j = 0; j < 6; j++) begin
            step4();
            check_eq("rr_chan", 32'(bus4.out_chan), 32'(j % 4));
            check_eq("rr_data", 32'(bus4.out_data), 32'(8'h10 + j % 4));
        end

        reset_n = 1'b0; step4(); reset_n = 1'b1;
        bus4.in_valid = 4'b0001;
        step4();
        bus4.in_valid = 4'b1001;
        step4(); check_eq("skip_a", 32'(bus4.out_chan), 32'd3);
        step4(); check_eq("skip_b", 32'(bus4.out_chan), 32'd0);
        step4(); check_eq("skip_c", 32'(bus4.out_chan), 32'd3);

        mode4 = 1'b0; sel4 = 2'd1; set_data4(1, 8'h3C); bus4.in_valid = 4'b0010;
        step4();
        check_eq("bp_load", 32'(bus4.out_data), 32'h3C);
        bus4.out_ready = 1'b0; mode4 = 1'b1; bus4.in_valid = 4'hF; set_data4(2, 8'h5A);
        repeat (3) begin
            step4();
            check_eq("bp_hold_data",  32'(bus4.out_data),  32'h3C);
            check_eq("bp_hold_valid", 32'(bus4.out_valid), 32'h1);
            check_eq("bp_hold_ready", 32'(bus4.in_ready),  32'h0);
        end
        bus4.out_ready = 1'b1;
        step4();
        check_eq("bp_nobubble_valid", 32'(bus4.out_valid), 32'h1);
        check_eq("bp_nobubble_chan",  32'(bus4.out_chan),  32'd2);
        check_eq("bp_nobubble_data",  32'(bus4.out_data),  32'h5A);

        bus4.out_ready = 1'b0;
        step4();
        reset_n = 1'b0;
        step4();
        check_eq("midrst_valid", 32'(bus4.out_valid), 32'h0);
        reset_n = 1'b1; bus4.out_ready = 1'b1;
        step4();
        check_eq("midrst_first", 32'(bus4.out_chan), 32'd0);

        // ---------------- N=4 instance: randomized ------------------------
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                if (!(bus4.in_valid[c] && m_last_g != c)) begin
                    bus4.in_valid[c] = ($urandom_range(0, 2) != 0);
                    bus4.in_data[c*W +: W] = 8'($urandom);
                end
            end
            bus4.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode4 = 1'($urandom);
            if ($urandom_range(0, 7) == 0)  sel4  = 2'($urandom);
            reset_n = ($urandom_range(0, 99) != 0);
            step4();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
